// File: rtl/param_sync_counter.sv
// Fully synchronous parametrised up/down counter with load, clear, cascade tc and wrap pulse.
// Define PARAM_SYNC_COUNTER_SATURATE_EN to make the count stop at the range ends instead of wrapping.
module param_sync_counter #(
   parameter int     WIDTH     = 4,
   parameter longint MODULUS   = 16,
   parameter longint RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             zero
);

   localparam longint           MAX_MOD = longint'(1) << WIDTH;
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

   if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > MAX_MOD ||
       RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
      $error("param_sync_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
   end

   logic             at_max;
   logic             at_min;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;

   assign at_max = (q == MAX_Q);
   assign at_min = (q == '0);
   assign tc     = en & ~load & ~clear & ~reset & ((up_dn & at_max) | (~up_dn & at_min));

   // Next value for the non-reset case; reset is applied in the register block.
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      if (clear) begin
         q_nxt = RST_Q;
      end else if (load) begin
         q_nxt = (load_val > MAX_Q) ? MAX_Q : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
               wrap_nxt = 1'b1;
`ifdef PARAM_SYNC_COUNTER_SATURATE_EN
               q_nxt    = MAX_Q;
`else
               q_nxt    = '0;
`endif
            end else begin
               q_nxt = q + WIDTH'(1);
            end
         end else begin
            if (at_min) begin
               wrap_nxt = 1'b1;
`ifdef PARAM_SYNC_COUNTER_SATURATE_EN
               q_nxt    = '0;
`else
               q_nxt    = MAX_Q;
`endif
            end else begin
               q_nxt = q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= RST_Q;
         wrap <= 1'b0;
         zero <= (RST_Q == '0);
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
         zero <= (q_nxt == '0);
      end
   end

endmodule

// File: tb/tb_param_sync_counter.sv
// Randomised self-checking bench for param_sync_counter against an integer reference model,
// plus a two-stage cascade built from tc.
module tb_param_sync_counter;

`ifdef PARAM_SYNC_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int MOD = 10;
   localparam int RV  = 3;

   logic       clk = 1'b0;
   logic       reset, en, up_dn, load, clear;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc, wrap, zero;

   logic       c_reset, c_en;
   logic [3:0] lo_q, hi_q;
   logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_zero, hi_zero;

   int n_cmp = 0;
   int n_err = 0;
   int m_q   = 0;
   bit m_w   = 1'b0;

   always #5 clk = ~clk;

   param_sync_counter #(.WIDTH(4), .MODULUS(MOD), .RESET_VAL(RV)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .q(q), .tc(tc), .wrap(wrap), .zero(zero)
   );

   param_sync_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_lo (
      .clk(clk), .reset(c_reset), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .clear(1'b0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .zero(lo_zero)
   );

   param_sync_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_hi (
      .clk(clk), .reset(c_reset), .en(lo_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .clear(1'b0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .zero(hi_zero)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: integer count in 0..mod-1; a step that would leave the range is a boundary crossing.
   function automatic void ref_step(input int mod, input int rv, input int cur,
                                    input bit r, input bit c, input bit l, input int lv,
                                    input bit e, input bit u, output int nq, output bit nw,
                                    output bit ntc);
      int t;
      t   = u ? cur + 1 : cur - 1;
      ntc = e && !l && !c && !r && (t < 0 || t >= mod);
      nw  = 1'b0;
      nq  = cur;
      if (r || c) begin
         nq = rv;
      end else if (l) begin
         nq = (lv < mod) ? lv : mod - 1;
      end else if (e) begin
         if (t < 0 || t >= mod) begin
            nw = 1'b1;
            nq = SAT ? cur : (t + mod) % mod;
         end else begin
            nq = t;
         end
      end
   endfunction

   task automatic step(input string tag);
      int nq;
      bit nw, etc;
      #1;
      ref_step(MOD, RV, m_q, reset, clear, load, int'(load_val), en, up_dn, nq, nw, etc);
      check_val({tag, ".tc"}, 64'(tc), 64'(etc));
      @(posedge clk);
      m_q = nq;
      m_w = nw;
      @(negedge clk);
      check_val({tag, ".q"}, 64'(q), 64'(m_q));
      check_val({tag, ".wrap"}, 64'(wrap), 64'(m_w));
      check_val({tag, ".zero"}, 64'(zero), 64'(m_q == 0));
   endtask

   task automatic drive(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
      reset    = r;
      clear    = c;
      load     = l;
      load_val = 4'(lv);
      en       = e;
      up_dn    = u;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lo_m, hi_m, t_lo, t_hi;
      bit w_dummy, lo_tc_m, hi_tc_m;

      drive(1, 0, 0, 0, 1, 1);
      c_reset = 1'b1;
      c_en    = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 3; i++) step("reset");
      check_val("reset.q_const", 64'(q), 64'(RV));
      drive(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 7; i++) step("upcount");
      check_val("upcount.q_end", 64'(q), SAT ? 64'(9) : 64'(0));
      step("upcount_after");

      drive(0, 0, 1, 9, 0, 1);  step("load9");
      drive(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step("upwrap");

      drive(0, 0, 1, 0, 0, 0);  step("load0");
      drive(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step("downwrap");

      drive(0, 0, 1, 12, 1, 1); step("clamp");
      check_val("clamp.q_abs", 64'(q), 64'(9));
      drive(0, 1, 1, 5, 1, 1);  step("clear_over_load");
      drive(0, 0, 1, 7, 1, 0);  step("load7");
      drive(1, 1, 1, 2, 1, 1);  step("reset_over_clear");

      drive(0, 0, 1, 9, 0, 1);  step("sat_load");
      drive(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step("sat_run");
      check_val("sat_run.q_abs", 64'(q), SAT ? 64'(9) : 64'(2));

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0, 1'($urandom));
         step("rand");
      end

      @(negedge clk);
      c_reset = 1'b0;
      c_en    = 1'b1;
      lo_m    = 0;
      hi_m    = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         ref_step(16, 0, lo_m, 0, 0, 0, 0, 1, 1, t_lo, w_dummy, lo_tc_m);
         ref_step(16, 0, hi_m, 0, 0, 0, 0, lo_tc_m, 1, t_hi, w_dummy, hi_tc_m);
         if (i % 50 == 0) begin
            check_val("cascade.lo_tc", 64'(lo_tc), 64'(lo_tc_m));
            check_val("cascade.hi_tc", 64'(hi_tc), 64'(hi_tc_m));
         end
         @(posedge clk);
         lo_m = t_lo;
         hi_m = t_hi;
         @(negedge clk);
      end
      check_val("cascade.value", 64'({hi_q, lo_q}), 64'(hi_m * 16 + lo_m));
      check_val("cascade.abs", 64'({hi_q, lo_q}), SAT ? 64'(255) : 64'(300 % 256));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
